// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon sequencer: colour codes, FSM states and
// the LFSR seed/tap definition used to pick new sequence colours.
package simon_pkg;

    typedef enum logic [1:0] {
        GREEN_IDX  = 2'd0,
        RED_IDX    = 2'd1,
        BLUE_IDX   = 2'd2,
        YELLOW_IDX = 2'd3
    } simon_col_t;

    typedef enum logic [3:0] {
        IDLE,
        ADD,
        PLAY_ON,
        PLAY_OFF,
        WAIT_IN,
        ECHO,
        GAP,
        LOSE,
        WIN
    } simon_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Fibonacci LFSR; reloads the seed on reset and exposes its
// low two bits as the next random colour.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] rnd
);

    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign rnd = lfsr[1:0];

endmodule

// File: rtl/simon_seq_ctrl.sv
// Simon game sequencer: grows a random colour sequence, plays it back, checks presses.
// Build macro SIMON_TIMEOUT_EN adds a player response timeout that ends the game.
module simon_seq_ctrl
    import simon_pkg::*;
#(
    parameter int  MS_TICKS     = 50000,
    parameter int  ON_MS        = 400,
    parameter int  OFF_MS       = 200,
    parameter int  ROUND_GAP_MS = 800,
    parameter int  MAX_LEN      = 32,
    parameter int  TIMEOUT_MS   = 3000,
    localparam int LVL_W        = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             btn_valid,
    input  logic [1:0]       btn_code,
    output logic [1:0]       col_sel,
    output logic             enable,
    output logic             loser,
    output logic             winner,
    output logic [LVL_W-1:0] level,
    output logic             busy
);

    localparam int IDX_W  = $clog2(MAX_LEN);
    localparam int PS_W   = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam int MAX_A  = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
    localparam int MAX_B  = (ROUND_GAP_MS > TIMEOUT_MS) ? ROUND_GAP_MS : TIMEOUT_MS;
    localparam int MS_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MS_W   = $clog2(MS_MAX + 1);

    simon_state_t     state;
    logic [PS_W-1:0]  presc;
    logic [MS_W-1:0]  ms_cnt;
    logic [LVL_W-1:0] idx;
    logic [LVL_W-1:0] idx_inc;
    logic [LVL_W-1:0] length;
    logic             match;
    logic [1:0]       rnd;
    logic [1:0]       mem [MAX_LEN];
    logic             tick;
    logic             on_done;
    logic             off_done;
    logic             gap_done;
    logic             start_ok;

    simon_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .rnd   (rnd)
    );

    // Prescaler and ms counter restart on every state change, so each state lasts
    // exactly N ms worth of clocks from its entry.
    assign tick     = (presc == PS_W'(MS_TICKS - 1));
    assign on_done  = tick && (ms_cnt == MS_W'(ON_MS - 1));
    assign off_done = tick && (ms_cnt == MS_W'(OFF_MS - 1));
    assign gap_done = tick && (ms_cnt == MS_W'(ROUND_GAP_MS - 1));
`ifdef SIMON_TIMEOUT_EN
    logic to_done;
    assign to_done  = tick && (ms_cnt == MS_W'(TIMEOUT_MS - 1));
`endif

    assign idx_inc  = idx + LVL_W'(1);
    assign start_ok = start && (state == IDLE || state == LOSE || state == WIN);
    assign level    = length;

    // Sequence memory holds data only; it persists across rounds and games.
    always_ff @(posedge clk) begin
        if (state == ADD) begin
            mem[length[IDX_W-1:0]] <= rnd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            presc   <= '0;
            ms_cnt  <= '0;
            idx     <= '0;
            length  <= '0;
            match   <= 1'b0;
            col_sel <= '0;
            enable  <= 1'b0;
            loser   <= 1'b0;
            winner  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (tick) begin
                presc  <= '0;
                ms_cnt <= ms_cnt + MS_W'(1);
            end else begin
                presc  <= presc + PS_W'(1);
            end

            if (start_ok) begin
                state  <= ADD;
                presc  <= '0;
                ms_cnt <= '0;
                length <= '0;
                loser  <= 1'b0;
                winner <= 1'b0;
                enable <= 1'b0;
                busy   <= 1'b1;
            end else begin
                case (state)
                    IDLE, LOSE: begin
                        enable <= 1'b0;
                    end

                    ADD: begin
                        state   <= PLAY_ON;
                        presc   <= '0;
                        ms_cnt  <= '0;
                        length  <= length + LVL_W'(1);
                        idx     <= '0;
                        enable  <= 1'b1;
                        // On the first round mem[0] is being written this very cycle.
                        col_sel <= (length == '0) ? rnd : mem[0];
                    end

                    PLAY_ON: begin
                        if (on_done) begin
                            state  <= PLAY_OFF;
                            presc  <= '0;
                            ms_cnt <= '0;
                            enable <= 1'b0;
                        end
                    end

                    PLAY_OFF: begin
                        if (off_done) begin
                            presc  <= '0;
                            ms_cnt <= '0;
                            if (idx_inc == length) begin
                                idx   <= '0;
                                state <= WAIT_IN;
                            end else begin
                                idx     <= idx_inc;
                                state   <= PLAY_ON;
                                enable  <= 1'b1;
                                col_sel <= mem[idx_inc[IDX_W-1:0]];
                            end
                        end
                    end

                    WAIT_IN: begin
                        if (btn_valid) begin
                            match   <= (btn_code == mem[idx[IDX_W-1:0]]);
                            enable  <= 1'b1;
                            col_sel <= btn_code;
                            state   <= ECHO;
                            presc   <= '0;
                            ms_cnt  <= '0;
                        end
`ifdef SIMON_TIMEOUT_EN
                        else if (to_done) begin
                            state  <= LOSE;
                            presc  <= '0;
                            ms_cnt <= '0;
                            loser  <= 1'b1;
                            busy   <= 1'b0;
                        end
`endif
                    end

                    ECHO: begin
                        if (on_done) begin
                            presc  <= '0;
                            ms_cnt <= '0;
                            enable <= 1'b0;
                            if (!match) begin
                                state <= LOSE;
                                loser <= 1'b1;
                                busy  <= 1'b0;
                            end else if (idx_inc == length) begin
                                if (length == LVL_W'(MAX_LEN)) begin
                                    state   <= WIN;
                                    winner  <= 1'b1;
                                    busy    <= 1'b0;
                                    enable  <= 1'b1;
                                    col_sel <= GREEN_IDX;
                                end else begin
                                    state <= GAP;
                                end
                            end else begin
                                idx   <= idx_inc;
                                state <= WAIT_IN;
                            end
                        end
                    end

                    GAP: begin
                        if (gap_done) begin
                            state  <= ADD;
                            presc  <= '0;
                            ms_cnt <= '0;
                        end
                    end

                    WIN: begin
                        if (on_done) begin
                            ms_cnt  <= '0;
                            col_sel <= (col_sel == YELLOW_IDX) ? GREEN_IDX : col_sel + 2'd1;
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
